// File: rtl/mem_rsp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_rsp : queued fixed-latency line memory with in-order replies    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_rsp #(
  parameter int PA_WIDTH    = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int ID_WIDTH    = 2,
  parameter int MEM_LINES   = 256,
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_enable,
  input  logic [PA_WIDTH-1:0]   i_mem_addr,
  input  logic [LINE_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_write,
  input  logic [ID_WIDTH-1:0]   i_mem_id,
  output logic                  o_mem_full,
  output logic                  o_mem_enable,
  output logic [LINE_WIDTH-1:0] o_mem_data,
  output logic [ID_WIDTH-1:0]   o_mem_id,
  output logic                  o_mem_write,
  output logic                  o_mem_busy
);

  localparam int c_LINE_BYTES = LINE_WIDTH / 8;
  localparam int c_OFF_W      = $clog2(c_LINE_BYTES);
  localparam int c_IDX_W      = $clog2(MEM_LINES);
  localparam int c_PTR_W      = $clog2(QUEUE_DEPTH);
  localparam int c_CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int c_ENT_W      = c_IDX_W + LINE_WIDTH + 1 + ID_WIDTH;

  localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W+1)'(QUEUE_DEPTH);
  localparam logic [c_PTR_W:0]   c_CNT_ONE = 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
  localparam logic [c_CNT_W-1:0] c_LAT_M1  = c_CNT_W'(LATENCY - 1);
  localparam logic [c_CNT_W-1:0] c_DEC_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_IDX_W-1:0]    r_act_idx;
  logic [LINE_WIDTH-1:0] r_act_data;
  logic                  r_act_write;
  logic [ID_WIDTH-1:0]   r_act_id;

  logic [c_ENT_W-1:0]    r_fifo [QUEUE_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_PTR_W:0]      r_count;

  logic [LINE_WIDTH-1:0] r_mem [MEM_LINES];

  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_mem_we;
  logic [c_IDX_W-1:0]    w_idx;
  logic [c_ENT_W-1:0]    w_head;
  logic [c_IDX_W-1:0]    w_head_idx;
  logic [LINE_WIDTH-1:0] w_head_data;
  logic                  w_head_write;
  logic [ID_WIDTH-1:0]   w_head_id;
  logic                  w_unused_addr;

  // Bits above the index are dropped, so addresses alias modulo the array size.
  assign w_idx         = i_mem_addr[c_OFF_W +: c_IDX_W];
  assign w_unused_addr = ^i_mem_addr;

  assign o_mem_full = (r_count == c_FULL);
  assign w_empty    = (r_count == '0);
  assign o_mem_busy = (r_state != S_IDLE) || !w_empty;
  assign w_push     = i_mem_enable && !o_mem_full;
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || (r_state == S_RESP));

  assign w_head       = r_fifo[r_rd_ptr];
  assign w_head_idx   = w_head[c_ENT_W-1 -: c_IDX_W];
  assign w_head_data  = w_head[ID_WIDTH+1 +: LINE_WIDTH];
  assign w_head_write = w_head[ID_WIDTH];
  assign w_head_id    = w_head[ID_WIDTH-1:0];

  // A write caught by reset on its final WAIT edge must not land in the array.
  assign w_mem_we = rst && (r_state == S_WAIT) && (r_cnt == '0) && r_act_write;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {w_idx, i_mem_data, i_mem_write, i_mem_id};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_act_idx] <= r_act_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_act_idx    <= '0;
      r_act_data   <= '0;
      r_act_write  <= 1'b0;
      r_act_id     <= '0;
      o_mem_enable <= 1'b0;
      o_mem_data   <= '0;
      o_mem_id     <= '0;
      o_mem_write  <= 1'b0;
    end else begin
      o_mem_enable <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_act_idx   <= w_head_idx;
            r_act_data  <= w_head_data;
            r_act_write <= w_head_write;
            r_act_id    <= w_head_id;
            r_cnt       <= c_LAT_M1;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_DEC_ONE;
          end else begin
            o_mem_enable <= 1'b1;
            o_mem_id     <= r_act_id;
            o_mem_write  <= r_act_write;
            o_mem_data   <= r_act_write ? r_act_data : r_mem[r_act_idx];
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          // Back-to-back requests skip IDLE to sustain one reply per LATENCY+1 cycles.
          if (w_pop) begin
            r_act_idx   <= w_head_idx;
            r_act_data  <= w_head_data;
            r_act_write <= w_head_write;
            r_act_id    <= w_head_id;
            r_cnt       <= c_LAT_M1;
            r_state     <= S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_rsp.sv
`default_nettype none
// Bench for mem_rsp: LATENCY=3 instance for function, LATENCY=1 instance for minimum latency.
module tb_mem_rsp;

  logic         clk = 1'b0;
  logic         rst = 1'b0;

  logic         a_en = 1'b0;
  logic [31:0]  a_addr = '0;
  logic [127:0] a_data = '0;
  logic         a_wr = 1'b0;
  logic [1:0]   a_id = '0;
  logic         a_ofull, a_oen, a_owr, a_obusy;
  logic [127:0] a_odata;
  logic [1:0]   a_oid;

  logic         b_en = 1'b0;
  logic [31:0]  b_addr = 32'h40;
  logic [127:0] b_data = '0;
  logic         b_wr = 1'b0;
  logic [1:0]   b_id = 2'd1;
  logic         b_ofull, b_oen, b_owr, b_obusy;
  logic [127:0] b_odata;
  logic [1:0]   b_oid;

  typedef struct {
    logic [127:0] data;
    logic [1:0]   id;
    logic         wr;
    int           cyc;
  } rsp_t;

  rsp_t a_q[$];
  int   b_cyc_q[$];
  int   cyc = 0;
  logic saw_full = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_rsp #(.PA_WIDTH(32), .LINE_WIDTH(128), .ID_WIDTH(2), .MEM_LINES(16),
            .LATENCY(3), .QUEUE_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst),
    .i_mem_enable(a_en), .i_mem_addr(a_addr), .i_mem_data(a_data),
    .i_mem_write(a_wr), .i_mem_id(a_id),
    .o_mem_full(a_ofull), .o_mem_enable(a_oen), .o_mem_data(a_odata),
    .o_mem_id(a_oid), .o_mem_write(a_owr), .o_mem_busy(a_obusy)
  );

  mem_rsp #(.PA_WIDTH(32), .LINE_WIDTH(128), .ID_WIDTH(2), .MEM_LINES(16),
            .LATENCY(1), .QUEUE_DEPTH(2)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .i_mem_enable(b_en), .i_mem_addr(b_addr), .i_mem_data(b_data),
    .i_mem_write(b_wr), .i_mem_id(b_id),
    .o_mem_full(b_ofull), .o_mem_enable(b_oen), .o_mem_data(b_odata),
    .o_mem_id(b_oid), .o_mem_write(b_owr), .o_mem_busy(b_obusy)
  );

  // Responses are logged with the index of the rising edge that produced them.
  always @(negedge clk) begin
    if (a_oen) a_q.push_back('{data: a_odata, id: a_oid, wr: a_owr, cyc: cyc});
    if (b_oen) b_cyc_q.push_back(cyc);
    if (a_ofull) saw_full = 1'b1;
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t get_a(input int i);
    rsp_t r;
    r = '{data: 'x, id: 'x, wr: 1'bx, cyc: -1};
    if (i < a_q.size()) r = a_q[i];
    return r;
  endfunction

  // Called at posedge+1; holds the request until an edge sees o_mem_full low.
  task automatic req_a(input logic [31:0] addr, input logic [127:0] data,
                       input logic wr, input logic [1:0] id, output int acc);
    logic f;
    logic ok;
    ok = 1'b0;
    acc = -1;
    a_en = 1'b1; a_addr = addr; a_data = data; a_wr = wr; a_id = id;
    for (int k = 0; k < 50 && !ok; k++) begin
      f = a_ofull;
      @(posedge clk);
      acc = cyc;
      ok = !f;
      #1;
    end
    a_en = 1'b0;
    if (!ok) chk("accept_timeout", 128'(ok), 128'd1);
  endtask

  task automatic wait_rsp(input int n, input string tag);
    for (int k = 0; k < 60 && a_q.size() < n; k++) begin
      @(posedge clk);
      #1;
    end
    chk(tag, 128'(a_q.size()), 128'(n));
  endtask

  initial begin
    int acc;
    int acc0;
    int bacc;
    rsp_t r;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_en",    128'(a_oen),   128'd0);
    chk("rst_full",  128'(a_ofull), 128'd0);
    chk("rst_busy",  128'(a_obusy), 128'd0);
    chk("rst_data",  a_odata,       128'd0);
    chk("rst_id",    128'(a_oid),   128'd0);
    chk("rst_wr",    128'(a_owr),   128'd0);
    chk("rst_b_out", {b_odata[123:0], b_oen, b_ofull, b_owr, b_obusy}, 128'd0);
    chk("rst_b_id",  128'(b_oid),   128'd0);
    rst = 1'b1;

    // Write then read the same line.
    req_a(32'h40, {16{8'hA5}}, 1'b1, 2'd1, acc);
    chk("busy_after_accept", 128'(a_obusy), 128'd1);
    wait_rsp(1, "wr_count");
    r = get_a(0);
    chk("wr_id",   128'(r.id),      128'd1);
    chk("wr_flag", 128'(r.wr),      128'd1);
    chk("wr_data", r.data,          {16{8'hA5}});
    chk("wr_lat",  128'(r.cyc - acc), 128'd4);

    req_a(32'h40, '0, 1'b0, 2'd2, acc);
    wait_rsp(2, "rd_count");
    r = get_a(1);
    chk("rd_id",   128'(r.id),      128'd2);
    chk("rd_flag", 128'(r.wr),      128'd0);
    chk("rd_data", r.data,          {16{8'hA5}});
    chk("rd_lat",  128'(r.cyc - acc), 128'd4);

    // 0x440 aliases onto line 4.
    req_a(32'h440, '0, 1'b0, 2'd0, acc);
    wait_rsp(3, "alias_count");
    chk("alias_data", get_a(2).data, {16{8'hA5}});

    // Four back-to-back reads through a two-entry queue.
    req_a(32'h40, '0, 1'b0, 2'd0, acc0);
    req_a(32'h40, '0, 1'b0, 2'd1, acc);
    req_a(32'h40, '0, 1'b0, 2'd2, acc);
    req_a(32'h40, '0, 1'b0, 2'd3, acc);
    wait_rsp(7, "bp_count");
    chk("bp_saw_full", 128'(saw_full), 128'd1);
    for (int i = 0; i < 4; i++) begin
      r = get_a(3 + i);
      chk($sformatf("bp_id%0d", i),  128'(r.id), 128'(i));
      chk($sformatf("bp_cyc%0d", i), 128'(r.cyc - acc0), 128'(4 * (i + 1)));
    end
    repeat (6) @(posedge clk);
    #1;
    chk("bp_no_extra", 128'(a_q.size()), 128'd7);

    // Reset in the second WAIT cycle of a write must drop it.
    req_a(32'h80, {4{32'h1234_5678}}, 1'b1, 2'd2, acc);
    wait_rsp(8, "pre_count");
    req_a(32'h80, {16{8'h3C}}, 1'b1, 2'd3, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid_full", 128'(a_ofull), 128'd0);
    chk("mid_busy", 128'(a_obusy), 128'd0);
    chk("mid_data", a_odata,       128'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_no_rsp", 128'(a_q.size()), 128'd8);
    req_a(32'h80, '0, 1'b0, 2'd0, acc);
    wait_rsp(9, "mid_rd_count");
    chk("mid_rd_data", get_a(8).data, {4{32'h1234_5678}});

    // Minimum latency on the LATENCY=1 instance.
    b_en = 1'b1;
    @(posedge clk);
    bacc = cyc;
    #1;
    b_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("l1_count", 128'(b_cyc_q.size()), 128'd1);
    if (b_cyc_q.size() > 0) chk("l1_lat", 128'(b_cyc_q[0] - bacc), 128'd2);
    else chk("l1_lat", 128'(-1), 128'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_rsp.md
MEM_RSP -- requirements
Module: mem_rsp

Interface
REQ-001 SHALL have parameter PA_WIDTH, default 32: request address width, byte-addressed.
REQ-002 SHALL have parameter LINE_WIDTH, default 128: line width in bits; LINE_BYTES = LINE_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 2: request tag width.
REQ-004 SHALL have parameter MEM_LINES, default 256: number of line-sized storage entries; power of two.
REQ-005 SHALL have parameter LATENCY, default 4: access delay in cycles; legal range is LATENCY >= 1.
REQ-006 SHALL have parameter QUEUE_DEPTH, default 4: request FIFO depth; power of two, >= 2.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset; one clock, reset synchronous and active-low (rst==0 resets).
REQ-009 SHALL have port i_mem_enable, input, 1 bit: request valid.
REQ-010 SHALL have port i_mem_addr, input, PA_WIDTH bits: request address.
REQ-011 SHALL have port i_mem_data, input, LINE_WIDTH bits: write line.
REQ-012 SHALL have port i_mem_write, input, 1 bit: 1 = write, 0 = read.
REQ-013 SHALL have port i_mem_id, input, ID_WIDTH bits: request tag.
REQ-014 SHALL have port o_mem_full, output, 1 bit: FIFO full; requests are not accepted.
REQ-015 SHALL have port o_mem_enable, output, 1 bit: response valid, a single-cycle pulse.
REQ-016 SHALL have port o_mem_data, output, LINE_WIDTH bits: response line.
REQ-017 SHALL have port o_mem_id, output, ID_WIDTH bits: tag of the response.
REQ-018 SHALL have port o_mem_write, output, 1 bit: 1 if the response completes a write.
REQ-019 SHALL have port o_mem_busy, output, 1 bit: 1 when the FSM is not IDLE or the FIFO is not empty.

Function
REQ-020 SHALL accept a request at a rising edge when i_mem_enable==1 and o_mem_full==0 at that edge.
- Accepted request: push {addr, data, write, id} into the FIFO.
REQ-021 SHALL ignore i_mem_enable while o_mem_full==1.
- No push, no error.
- Requester holds its request until accepted.
REQ-022 SHALL drive o_mem_full = (count == QUEUE_DEPTH), as a registered-count decode.
- No same-cycle pop bypass.
REQ-023 SHALL compute the line index as i_mem_addr[$clog2(LINE_BYTES) +: $clog2(MEM_LINES)].
- Upper address bits are ignored, so addresses alias modulo MEM_LINES*LINE_BYTES.
REQ-024 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-025 In IDLE, SHALL behave as follows:
- FIFO non-empty: pop the head into the active register, load counter = LATENCY-1, go to WAIT.
- FIFO empty: stay in IDLE.
REQ-026 In WAIT, SHALL behave as follows:
- counter>0: decrement.
- counter==0, write: store the line at the index.
- counter==0, read: latch the array line into o_mem_data.
- counter==0, then go to RESP.
REQ-027 In RESP, SHALL behave as follows:
- Outputs: o_mem_enable=1; o_mem_id = active id; o_mem_write = active write flag.
- o_mem_data = read line, or the written line for a write.
- Next edge: if the FIFO is non-empty, pop and go to WAIT directly; otherwise go to IDLE.
REQ-028 SHALL, for an idle block, raise o_mem_enable exactly LATENCY+1 cycles after the accepting edge.
- Sustained throughput is one response per LATENCY+1 cycles.
REQ-029 SHALL return responses strictly in acceptance order, so a read after a write to the same line returns the new data.
REQ-030 SHALL allow a push and a pop on the same edge; count is unchanged.
REQ-031 SHALL hold o_mem_enable at 0 outside RESP.
- o_mem_data/o_mem_id/o_mem_write are don't-care when o_mem_enable==0, but hold their last value.

Reset
REQ-032 SHALL, on an edge with rst==0, empty the FIFO (pointers and count = 0), set the FSM to IDLE and set counter = 0.
REQ-033 SHALL, on reset, set every output to 0.
REQ-034 SHALL discard any in-flight or queued request on reset; no response is issued.
- A write still in WAIT is not stored.
- Array contents SHALL NOT be cleared by reset and power up as zero.

Verification
Defaults for all scenarios: LINE_WIDTH=128, MEM_LINES=16, LATENCY=3, QUEUE_DEPTH=2, ID_WIDTH=2.
REQ-035 SHALL verify write then read:
- Stimulus: write addr 0x40, data 0xA5..A5, id 1; then read 0x40, id 2.
- Response: pulse o_mem_write=1, o_mem_id=1 4 cycles after accept; read returns 0xA5..A5, o_mem_id=2.
REQ-036 SHALL verify aliasing:
- Stimulus: after REQ-035, read 0x440.
- Response: returns 0xA5..A5 (index 4).
REQ-037 SHALL verify backpressure:
- Stimulus: 4 back-to-back reads, ids 0,1,2,3, each i_mem_enable held until accepted.
- Response: o_mem_full=1 appears at least once; 4 responses, ids 0,1,2,3 in order, each 4 cycles apart.
REQ-038 SHALL verify reset mid-operation:
- Stimulus: write 0x80 id 3; assert rst at the second WAIT cycle.
- Response: no o_mem_enable; o_mem_full=0 and o_mem_busy=0 after reset; a later read of 0x80 returns the prior value.
REQ-039 SHALL verify minimum latency:
- Stimulus: LATENCY=1, single read.
- Response: o_mem_enable is high exactly 2 cycles after the accepting edge, for 1 cycle.
